// File: rtl/ldpc_pkg.sv
// Shared constants and FSM encoding for the CMMB LDPC encoder.
// Frame length is 9216 bits; the syndrome is sized for the larger parity set.
package ldpc_pkg;
    localparam int N       = 9216;
    localparam int RATE0_K = 4608;
    localparam int RATE1_K = 6912;
    localparam int Z       = 256;
    localparam int AW      = 13;
    localparam int MMAX    = N - RATE0_K;

    typedef enum logic [1:0] {IDLE, LOAD, DRAIN, PARITY} state_t;

    function automatic logic [AW-1:0] k_of(input logic rate);
        return rate ? AW'(RATE1_K) : AW'(RATE0_K);
    endfunction

    function automatic logic [AW-1:0] m_of(input logic rate);
        return rate ? AW'(N - RATE1_K) : AW'(N - RATE0_K);
    endfunction
endpackage

// File: rtl/ldpc_enc_rom.sv
// Column-to-row address table: three parity-row addresses per info column,
// registered with one cycle of latency.
module ldpc_enc_rom
    import ldpc_pkg::*;
(
    input  logic          clk,
    input  logic          reset_n,
    input  logic          i_rate,
    input  logic [AW-1:0] i_col,
    output logic [AW-1:0] o_a0,
    output logic [AW-1:0] o_a1,
    output logic [AW-1:0] o_a2
);
    // Each column's three ones sit in distinct 256-row circulant blocks
    // (block offsets 0/3/6 mod the block count), so addresses never collide.
    function automatic logic [AW-1:0] col_addr(input logic rate, input logic [AW-1:0] col,
                                               input logic [1:0] k);
        logic [5:0] t;
        logic [4:0] mb;
        logic [7:0] sh;
        t  = {1'b0, col[12:8]} + 6'(k) * 6'd3;
        mb = rate ? 5'd9 : 5'd18;
        for (int i = 0; i < 3; i++)
            if (t >= {1'b0, mb}) t = t - {1'b0, mb};
        sh = col[7:0] + 8'(col[12:8]) * 8'd37 + 8'(k) * 8'd91 + 8'd13;
        return {t[4:0], sh};
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            o_a0 <= '0;
            o_a1 <= '0;
            o_a2 <= '0;
        end else begin
            o_a0 <= col_addr(i_rate, i_col, 2'd0);
            o_a1 <= col_addr(i_rate, i_col, 2'd1);
            o_a2 <= col_addr(i_rate, i_col, 2'd2);
        end
    end
endmodule

// File: rtl/ldpc_enc.sv
// Serial systematic LDPC encoder: echoes K info bits, then emits M parity
// bits from the dual-diagonal prefix-XOR of the accumulated syndrome.
module ldpc_enc
    import ldpc_pkg::*;
(
    input  logic clk,
    input  logic reset_n,
    input  logic data_in,
    input  logic sync_in,
    input  logic rate,
    output logic data_out,
    output logic sync_out,
    output logic busy
);
    state_t          r_state, w_next;
    logic            r_rate, r_drain, r_bit_d, r_tog_v, r_acc, r_dout, r_sout;
    logic [AW-1:0]   r_bit_cnt, r_par_cnt;
    logic [MMAX-1:0] r_syn;
    logic [AW-1:0]   w_k, w_m, w_col, w_a0, w_a1, w_a2;
    logic            w_start, w_echo, w_par, w_busy;

    // The last parity bit is still on the output when the FSM is back in IDLE.
    assign w_busy  = (r_state != IDLE) || r_sout;
    assign w_start = (r_state == IDLE) && sync_in && !r_sout;
    assign w_echo  = w_start || ((r_state == LOAD) && sync_in);
    assign w_k     = k_of(r_rate);
    assign w_m     = m_of(r_rate);
    assign w_col   = (r_state == IDLE) ? '0 : r_bit_cnt;
    assign w_par   = r_acc ^ r_syn[r_par_cnt];

    assign data_out = r_dout;
    assign sync_out = r_sout;
    assign busy     = w_busy;

    ldpc_enc_rom u_rom (
        .clk     (clk),
        .reset_n (reset_n),
        .i_rate  ((r_state == IDLE) ? rate : r_rate),
        .i_col   (w_col),
        .o_a0    (w_a0),
        .o_a1    (w_a1),
        .o_a2    (w_a2)
    );

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (w_start) w_next = LOAD;
            LOAD:    if (!sync_in) w_next = IDLE;
                     else if (r_bit_cnt == w_k - AW'(1)) w_next = DRAIN;
            DRAIN:   if (r_drain) w_next = PARITY;
            PARITY:  if (r_par_cnt == w_m - AW'(1)) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= IDLE;
            r_rate    <= 1'b0;
            r_drain   <= 1'b0;
            r_bit_d   <= 1'b0;
            r_tog_v   <= 1'b0;
            r_acc     <= 1'b0;
            r_dout    <= 1'b0;
            r_sout    <= 1'b0;
            r_bit_cnt <= '0;
            r_par_cnt <= '0;
            r_syn     <= '0;
        end else begin
            r_state <= w_next;
            r_sout  <= w_echo || (r_state == PARITY);
            r_dout  <= w_echo ? data_in : ((r_state == PARITY) ? w_par : 1'b0);
            r_bit_d <= data_in;
            r_tog_v <= w_echo;
            r_drain <= (r_state == DRAIN) ? ~r_drain : 1'b0;
            // Column 0 is presented to the ROM in the start cycle itself.
            if (w_start) begin
                r_rate    <= rate;
                r_bit_cnt <= AW'(1);
            end else if ((r_state == LOAD) && sync_in) begin
                r_bit_cnt <= r_bit_cnt + AW'(1);
            end
            if (r_state == DRAIN) begin
                r_par_cnt <= '0;
                r_acc     <= 1'b0;
            end else if (r_state == PARITY) begin
                r_par_cnt <= r_par_cnt + AW'(1);
                r_acc     <= w_par;
            end
            // A new frame's clear wins over a trailing toggle from an aborted one.
            if (w_start) begin
                r_syn <= '0;
            end else if (r_tog_v && r_bit_d) begin
                r_syn[w_a0] <= ~r_syn[w_a0];
                r_syn[w_a1] <= ~r_syn[w_a1];
                r_syn[w_a2] <= ~r_syn[w_a2];
            end
        end
    end
endmodule

// File: tb/tb_ldpc_enc.sv
// Bench for ldpc_enc: frame-level reference encoder, table of frame scenarios,
// plus hand sequences for back-to-back frames and reset during parity.
module tb_ldpc_enc;
    logic clk = 1'b0;
    logic reset_n, data_in, sync_in, rate;
    logic data_out, sync_out, busy;

    int vecs = 0;
    int errs = 0;

    logic u    [0:6911];
    logic gs   [0:4607];
    logic gp   [0:4607];
    logic hsyn [0:4607];
    logic ob   [0:9215];

    always #5 clk = ~clk;

    ldpc_enc dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .data_in  (data_in),
        .sync_in  (sync_in),
        .rate     (rate),
        .data_out (data_out),
        .sync_out (sync_out),
        .busy     (busy)
    );

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Parity-check table: row address of the k-th one in info column j.
    function automatic int addr_of(input int rt, input int j, input int k);
        int mb, b, r;
        mb = (rt != 0) ? 9 : 18;
        b  = j / 256;
        r  = j % 256;
        return ((b + 3 * k) % mb) * 256 + (r + b * 37 + k * 91 + 13) % 256;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        vecs++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic step(input logic si, input logic di, input logic rt,
                        output logic so, output logic dout, output logic bsy);
        sync_in = si;
        data_in = di;
        rate    = rt;
        @(negedge clk);
        so   = sync_out;
        dout = data_out;
        bsy  = busy;
        @(posedge clk);
        #1;
    endtask

    task automatic golden(input int rt);
        int k, m;
        logic acc;
        k = (rt != 0) ? 6912 : 4608;
        m = 9216 - k;
        for (int i = 0; i < m; i++) gs[i] = 1'b0;
        for (int j = 0; j < k; j++)
            if (u[j])
                for (int kk = 0; kk < 3; kk++) gs[addr_of(rt, j, kk)] ^= 1'b1;
        acc = 1'b0;
        for (int i = 0; i < m; i++) begin
            acc   = acc ^ gs[i];
            gp[i] = acc;
        end
    endtask

    // mode: 0 all-zero, 1 random, 2 single one at index 0.
    task automatic run_frame(input int rt, input int mode, input int ntx, input int stray,
                             input int tail, input int exp_n, input int exp_bf);
        int k, m, last, nsync, sync_err, busy_err, bf, info_err, perr, herr, lo, mid, hi, tmp;
        logic so, dout, bsy, es, eb, si, di, rtb, prev;
        k   = (rt != 0) ? 6912 : 4608;
        m   = 9216 - k;
        rtb = (rt != 0);
        for (int j = 0; j < k; j++)
            u[j] = (mode == 1) ? 1'($urandom) : ((mode == 2) && (j == 0));
        last = (ntx < k) ? ntx + 2 : k + m + 2 + tail;
        nsync = 0; sync_err = 0; busy_err = 0; bf = -1;
        for (int c = 0; c <= last; c++) begin
            si = (c < ntx) || ((stray != 0) && c >= k + 1 && c <= k + 20);
            di = (c < ntx) ? u[c] : 1'($urandom);
            step(si, di, (c == 0) ? rtb : !rtb, so, dout, bsy);
            if (ntx < k) begin
                es = (c >= 1 && c <= ntx);
                eb = (c >= 1 && c <= ntx);
            end else begin
                es = (c >= 1 && c <= k) || (c >= k + 3 && c <= k + m + 2);
                eb = (c >= 1 && c <= k + m + 2);
            end
            if (so !== es) sync_err++;
            if (bsy !== eb) busy_err++;
            if (c >= 1 && bsy === 1'b0 && bf < 0) bf = c;
            if (so === 1'b1) begin
                if (nsync < 9216) ob[nsync] = dout;
                nsync++;
            end
        end
        chk("sync_count", nsync, exp_n);
        chk("sync_pattern", sync_err, 0);
        chk("busy_pattern", busy_err, 0);
        if (exp_bf >= 0) chk("busy_fall", bf, exp_bf);
        info_err = 0;
        for (int i = 0; i < ((nsync < ntx) ? nsync : ntx); i++)
            if (ob[i] !== u[i]) info_err++;
        chk("info_bits", info_err, 0);
        if (ntx >= k && nsync == 9216) begin
            golden(rt);
            perr = 0;
            for (int i = 0; i < m; i++) if (ob[k + i] !== gp[i]) perr++;
            chk("parity_golden", perr, 0);
            for (int i = 0; i < m; i++) hsyn[i] = 1'b0;
            for (int j = 0; j < k; j++)
                if (ob[j] === 1'b1)
                    for (int kk = 0; kk < 3; kk++) hsyn[addr_of(rt, j, kk)] ^= 1'b1;
            herr = 0;
            for (int i = 0; i < m; i++) begin
                prev = (i > 0) ? ob[k + i - 1] : 1'b0;
                if ((hsyn[i] ^ ob[k + i] ^ prev) !== 1'b0) herr++;
            end
            chk("H_times_c", herr, 0);
            if (mode == 2) begin
                lo = addr_of(rt, 0, 0); mid = addr_of(rt, 0, 1); hi = addr_of(rt, 0, 2);
                if (lo > mid) begin tmp = lo; lo = mid; mid = tmp; end
                if (mid > hi) begin tmp = mid; mid = hi; hi = tmp; end
                if (lo > mid) begin tmp = lo; lo = mid; mid = tmp; end
                perr = 0;
                for (int i = 0; i < m; i++)
                    if (ob[k + i] !== ((i >= lo && i < mid) || i >= hi)) perr++;
                chk("unit_ranges", perr, 0);
            end
        end
    endtask

    typedef struct {
        int rt;
        int mode;
        int ntx;
        int exp_n;
        int exp_bf;
    } vec_t;

    initial begin
        vec_t tbl [5];
        logic so, dout, bsy;
        tbl[0] = '{0, 0, 4608, 9216, 9219};
        tbl[1] = '{0, 1, 4608, 9216, 9219};
        tbl[2] = '{1, 1, 6912, 9216, 9219};
        tbl[3] = '{0, 2, 4608, 9216, 9219};
        tbl[4] = '{0, 1, 100, 100, 101};

        void'($urandom(32'h1d9c));
        reset_n = 1'b0; sync_in = 1'b0; data_in = 1'b0; rate = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_data_out", int'(data_out), 0);
        chk("reset_sync_out", int'(sync_out), 0);
        chk("reset_busy", int'(busy), 0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 5; i++)
            run_frame(tbl[i].rt, tbl[i].mode, tbl[i].ntx, 0, 2, tbl[i].exp_n, tbl[i].exp_bf);

        // Back-to-back: stray sync_in during the first frame's gap and parity,
        // second frame starts on the first cycle busy is low.
        run_frame(1, 1, 6912, 1, 0, 9216, -1);
        run_frame(0, 1, 4608, 0, 2, 9216, 9219);

        // Reset pulsed while parity is streaming out.
        for (int c = 0; c <= 6912 + 50; c++)
            step(c < 6912, 1'($urandom), c == 0, so, dout, bsy);
        chk("pre_reset_sync_out", int'(so), 1);
        reset_n = 1'b0;
        #1;
        chk("mid_reset_sync_out", int'(sync_out), 0);
        chk("mid_reset_busy", int'(busy), 0);
        chk("mid_reset_data_out", int'(data_out), 0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        run_frame(0, 1, 4608, 0, 2, 9216, 9219);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule

// File: doc/ldpc_enc.md
# ldpc_enc

Systematic LDPC encoder for the 9216-bit CMMB codeword, rates 1/2 (K=4608, M=4608) and 3/4 (K=6912, M=2304). Accepts a serial frame of K information bits and emits the full codeword serially: info bits first, then M parity bits. It is the transmit-side counterpart of `ldpc`. Its 1-bit output, after mapping to soft values, is the reference stimulus source for decoder verification.

## Interface
- `RATE0_K`, 4608: info bits at rate 1/2
- `RATE1_K`, 6912: info bits at rate 3/4
- `N`, 9216: codeword length
- `clk`  in  1  system clock, all logic on rising edge
- `reset_n`  in  1  asynchronous active-low reset
- `data_in`  in  1  info bit, valid when `sync_in`=1
- `sync_in`  in  1  frame valid; high for exactly K consecutive cycles per frame
- `rate`  in  1  0 = rate 1/2, 1 = rate 3/4; sampled on the first `sync_in` cycle of a frame
- `data_out`  out  1  codeword bit, valid when `sync_out`=1
- `sync_out`  out  1  output bit valid
- `busy`  out  1  frame in progress; new frames are not accepted while high

## Operation
- H = [H_i | H_p]. Each info column j has exactly 3 ones, at parity-row addresses a0(j), a1(j), a2(j) (13 bits each, < M), read from `ldpc_enc_rom`. H_p is dual-diagonal, so p[0]=s[0] and p[i]=p[i-1]^s[i], where s = H_i·u.
- State machine:
  - IDLE → LOAD on `sync_in`=1. Latch `rate`, set K/M, clear the syndrome register s[0:M-1], set `bit_cnt`=0.
  - LOAD: each cycle with `sync_in`=1, `bit_cnt`++ and present column `bit_cnt` to the ROM. One cycle later, if the delayed bit is 1, toggle s[a0], s[a1], s[a2]. Duplicate addresses within a column must not occur; the ROM guarantees this.
  - LOAD → DRAIN when `bit_cnt` reaches K.
  - LOAD → IDLE (abort) if `sync_in` falls before K bits. An abort produces no parity output.
  - DRAIN: 2 cycles for the ROM/toggle pipeline to finish, then → PARITY with `par_cnt`=0 and `acc`=0.
  - PARITY: each cycle `acc`←`acc`^s[`par_cnt`], output `acc`^s[`par_cnt`], `par_cnt`++. After M bits → IDLE.
- Any `sync_in` outside IDLE, other than the K frame bits, is ignored.
- Bit counters are 13 bits wide and never wrap within a frame.

## Timing
- Cycle 0 is the first `sync_in`=1 cycle.
- Info bits: `data_out` = `data_in` delayed by 1 cycle, with `sync_out`=1 on cycles 1..K.
- Gap: `sync_out`=0 on cycles K+1 and K+2.
- Parity bits: `sync_out`=1 on cycles K+3..K+M+2, parity p[0] first.
- `busy`: 1 from cycle 1 through cycle K+M+2, 0 on cycle K+M+3. The earliest next-frame `sync_in` is cycle K+M+3.
- Reset values: `data_out`=0, `sync_out`=0, `busy`=0, state=IDLE, s all 0.
- Reset mid-frame: immediate return to IDLE and the frame is lost. The next frame after reset encodes correctly.
- Abort: `busy` falls the cycle after `sync_in` falls. `sync_out` stops at the same time as the echoed info bits.

## Structure
- Package `ldpc_pkg` holds:
  - the constants N, RATE0_K, RATE1_K, circulant size 256, and address width 13;
  - the state enum IDLE/LOAD/DRAIN/PARITY.
- Sub-module `ldpc_enc_rom`:
  - inputs: `rate`, 13-bit column index;
  - outputs: three 13-bit addresses, registered with 1-cycle latency;
  - contents generated from the CMMB H tables and shared with the decoder's address tables.
- Top level contains the FSM, the counters, the M-bit syndrome register (sized for 4608) and the output mux.

## Test plan
- All-zero info, rate 0 → 4608 zero info bits, a 2-cycle gap, then 4608 zero parity bits; exactly 9216 `sync_out` pulses; `busy` falls on cycle 9219.
- Random info from a fixed seed, rate 0 and rate 1 → output bit-exact against the C golden encoder, and H·c=0 checked in the bench. Rate 1 gives 6912+2304 bits, with `busy` falling on cycle 9219.
- Single 1 at info index 0, rate 0 → parity is the prefix-XOR of the unit syndrome at a0(0), a1(0), a2(0). Parity is 1 exactly on the index ranges [min, mid) and [max, M) of the sorted addresses.
- `sync_in` dropped after 100 bits → 100 echoed bits, no parity, `busy`=0 on cycle 101. The next full frame matches golden.
- `reset_n` pulsed low during PARITY → outputs 0 immediately. A following frame matches golden, proving no syndrome residue.
- Back-to-back frames, second `sync_in` at cycle K+M+3 → both codewords correct. A `sync_in` asserted during `busy` is ignored.
